fft_dif_bf_stage: RTL and testbench

- Parametrised radix-2 DIF butterfly stage for the parallel-lane FFT datapath; it owns its own delay buffer and control FSM.
- Accepts LANES complex samples per valid beat. The first DEPTH beats of each frame half are buffered; each of the next DEPTH beats is paired lane-for-lane with the buffered beat of the same index, producing registered add and sub outputs with a valid strobe.
- Generalises the fixed 16-lane, single-beat stage 0 block to arbitrary width, lane count and butterfly distance, adds optional per-frame 1/2 scaling, and tolerates gaps in din_valid.

---
 rtl/fft_dif_bf_stage.sv | 147 ++++++++++++++
 tb/tb_fft_dif_bf_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_dif_bf_stage.sv
// Radix-2 DIF butterfly stage. The first DEPTH beats of each frame half are stored,
// then each following beat is paired lane-for-lane with the stored beat of the same index.
//
// state | meaning
// FILL  | storing beats 0..DEPTH-1 of the frame half into the delay buffer
// PAIR  | combining incoming beats with buffered beats, emitting add/sub results
module fft_dif_bf_stage #(
    parameter int WIDTH = 9,
    parameter int LANES = 16,
    parameter int DEPTH = 16,
    parameter int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         din_valid,
    input  logic [LANES*WIDTH-1:0]       din_i,
    input  logic [LANES*WIDTH-1:0]       din_q,
    input  logic                         scale_en,
    output logic                         dout_valid,
    output logic [IDXW-1:0]              dout_idx,
    output logic [LANES*(WIDTH+1)-1:0]   dout_add_r,
    output logic [LANES*(WIDTH+1)-1:0]   dout_add_i,
    output logic [LANES*(WIDTH+1)-1:0]   dout_sub_r,
    output logic [LANES*(WIDTH+1)-1:0]   dout_sub_i
);

    localparam int OW = WIDTH + 1;
    localparam int EW = WIDTH + 2;
    localparam int RW = 2 * LANES * WIDTH;
    localparam logic [IDXW-1:0] LAST = IDXW'(DEPTH - 1);
    localparam logic signed [EW-1:0] ONE = EW'(1);

    typedef enum logic {FILL = 1'b0, PAIR = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] cnt_q, cnt_d;
    logic            scale_q, scale_d;
    logic            pair_fire;

    logic [RW-1:0]   buf_q [DEPTH];
    logic [RW-1:0]   row_a;

    logic                  dout_valid_q;
    logic [IDXW-1:0]       dout_idx_q;
    logic [LANES*OW-1:0]   add_r_q, add_i_q, sub_r_q, sub_i_q;
    logic [LANES*OW-1:0]   add_r_d, add_i_d, sub_r_d, sub_i_d;

    function automatic logic signed [EW-1:0] sext(input logic [WIDTH-1:0] v);
        return {{2{v[WIDTH-1]}}, v};
    endfunction

    // Scaled path rounds half up: (r + 1) >>> 1 always fits back into OW bits.
    function automatic logic [OW-1:0] fit(input logic signed [EW-1:0] r, input logic s);
        logic signed [EW-1:0] h;
        h = (r + ONE) >>> 1;
        return s ? h[OW-1:0] : r[OW-1:0];
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        scale_d   = scale_q;
        pair_fire = 1'b0;
        if (din_valid) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + IDXW'(1);
            end
            case (state_q)
                FILL: begin
                    if (cnt_q == '0) begin
                        scale_d = scale_en;
                    end
                    if (cnt_q == LAST) begin
                        state_d = PAIR;
                    end
                end
                PAIR: begin
                    pair_fire = 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = FILL;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    assign row_a = buf_q[cnt_q];

    always_comb begin
        add_r_d = '0;
        add_i_d = '0;
        sub_r_d = '0;
        sub_i_d = '0;
        for (int k = 0; k < LANES; k++) begin
            add_r_d[k*OW +: OW] = fit(sext(row_a[k*WIDTH +: WIDTH]) + sext(din_i[k*WIDTH +: WIDTH]), scale_q);
            sub_r_d[k*OW +: OW] = fit(sext(row_a[k*WIDTH +: WIDTH]) - sext(din_i[k*WIDTH +: WIDTH]), scale_q);
            add_i_d[k*OW +: OW] = fit(sext(row_a[LANES*WIDTH + k*WIDTH +: WIDTH])
                                      + sext(din_q[k*WIDTH +: WIDTH]), scale_q);
            sub_i_d[k*OW +: OW] = fit(sext(row_a[LANES*WIDTH + k*WIDTH +: WIDTH])
                                      - sext(din_q[k*WIDTH +: WIDTH]), scale_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= FILL;
            cnt_q        <= '0;
            scale_q      <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_idx_q   <= '0;
            add_r_q      <= '0;
            add_i_q      <= '0;
            sub_r_q      <= '0;
            sub_i_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            scale_q      <= scale_d;
            dout_valid_q <= pair_fire;
            if (pair_fire) begin
                dout_idx_q <= cnt_q;
                add_r_q    <= add_r_d;
                add_i_q    <= add_i_d;
                sub_r_q    <= sub_r_d;
                sub_i_q    <= sub_i_d;
            end
        end
    end

    // Buffer contents need no reset; a row is always written in FILL before PAIR reads it.
    always_ff @(posedge clk) begin
        if (din_valid && state_q == FILL) begin
            buf_q[cnt_q] <= {din_q, din_i};
        end
    end

    assign dout_valid = dout_valid_q;
    assign dout_idx   = dout_idx_q;
    assign dout_add_r = add_r_q;
    assign dout_add_i = add_i_q;
    assign dout_sub_r = sub_r_q;
    assign dout_sub_i = sub_i_q;

endmodule

// File: tb/tb_fft_dif_bf_stage.sv
// Scoreboard bench for fft_dif_bf_stage: three instances (DEPTH 2, 1, 16), directed
// vectors plus a random continuous stream, each output checked for cycle, index and data.
`timescale 1ns/1ps
module tb_fft_dif_bf_stage;
    localparam int W  = 9;
    localparam int L  = 16;
    localparam int IV = L * W;
    localparam int OV = L * (W + 1);

    typedef struct {
        int            ecnt;
        int            idx;
        logic [OV-1:0] ar, ai, sr, si;
    } exp_t;

    exp_t q2[$], q1[$], q16[$];
    int   checks = 0, failures = 0;
    int   ecount = 0;

    logic clk = 1'b0, rstn;
    always #5 clk = ~clk;
    always @(posedge clk) ecount <= ecount + 1;

    logic          v2, v1, v16, se2, se1, se16;
    logic [IV-1:0] ir2, iq2, ir1, iq1, ir16, iq16;
    logic          ov2, ov1, ov16;
    logic [0:0]    ox2, ox1;
    logic [3:0]    ox16;
    logic [OV-1:0] ar2, ai2, sr2, si2, ar1, ai1, sr1, si1, ar16, ai16, sr16, si16;

    fft_dif_bf_stage #(.WIDTH(W), .LANES(L), .DEPTH(2)) u_d2 (
        .clk(clk), .rstn(rstn), .din_valid(v2), .din_i(ir2), .din_q(iq2), .scale_en(se2),
        .dout_valid(ov2), .dout_idx(ox2), .dout_add_r(ar2), .dout_add_i(ai2),
        .dout_sub_r(sr2), .dout_sub_i(si2));
    fft_dif_bf_stage #(.WIDTH(W), .LANES(L), .DEPTH(1)) u_d1 (
        .clk(clk), .rstn(rstn), .din_valid(v1), .din_i(ir1), .din_q(iq1), .scale_en(se1),
        .dout_valid(ov1), .dout_idx(ox1), .dout_add_r(ar1), .dout_add_i(ai1),
        .dout_sub_r(sr1), .dout_sub_i(si1));
    fft_dif_bf_stage #(.WIDTH(W), .LANES(L), .DEPTH(16)) u_d16 (
        .clk(clk), .rstn(rstn), .din_valid(v16), .din_i(ir16), .din_q(iq16), .scale_en(se16),
        .dout_valid(ov16), .dout_idx(ox16), .dout_add_r(ar16), .dout_add_i(ai16),
        .dout_sub_r(sr16), .dout_sub_i(si16));

    function automatic logic [IV-1:0] pk9f(input int base, input int step);
        logic [IV-1:0] r;
        int v;
        r = '0;
        for (int k = 0; k < L; k++) begin
            v = base + step * k;
            r[k*W +: W] = v[W-1:0];
        end
        return r;
    endfunction

    function automatic logic [OV-1:0] pk10f(input int base, input int step);
        logic [OV-1:0] r;
        int v;
        r = '0;
        for (int k = 0; k < L; k++) begin
            v = base + step * k;
            r[k*(W+1) +: W+1] = v[W:0];
        end
        return r;
    endfunction

    function automatic logic [IV-1:0] pk9a(input int a[L]);
        logic [IV-1:0] r;
        int v;
        r = '0;
        for (int k = 0; k < L; k++) begin
            v = a[k];
            r[k*W +: W] = v[W-1:0];
        end
        return r;
    endfunction

    function automatic logic [OV-1:0] pk10a(input int a[L]);
        logic [OV-1:0] r;
        int v;
        r = '0;
        for (int k = 0; k < L; k++) begin
            v = a[k];
            r[k*(W+1) +: W+1] = v[W:0];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [OV-1:0] act, input logic [OV-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic cmp(input string nm, input exp_t e, input int idx,
                       input logic [OV-1:0] ar, ai, sr, si);
        chki({nm, ".cycle"}, ecount, e.ecnt);
        chki({nm, ".idx"}, idx, e.idx);
        chk({nm, ".add_r"}, ar, e.ar);
        chk({nm, ".add_i"}, ai, e.ai);
        chk({nm, ".sub_r"}, sr, e.sr);
        chk({nm, ".sub_i"}, si, e.si);
    endtask

    task automatic unexpected(input string nm);
        checks++;
        failures++;
        $display("FAIL %s unexpected dout_valid at cycle %0d, required none", nm, ecount);
    endtask

    task automatic rchk(input string nm, input logic v, input int idx,
                        input logic [OV-1:0] ar, ai, sr, si);
        chki({nm, ".rst_valid"}, int'(v), 0);
        chki({nm, ".rst_idx"}, idx, 0);
        chk({nm, ".rst_add_r"}, ar, '0);
        chk({nm, ".rst_add_i"}, ai, '0);
        chk({nm, ".rst_sub_r"}, sr, '0);
        chk({nm, ".rst_sub_i"}, si, '0);
    endtask

    // Monitors: pop one expectation per presented output.
    always @(negedge clk) begin
        if (ov2 === 1'b1) begin
            if (q2.size() == 0) unexpected("d2");
            else cmp("d2", q2.pop_front(), int'(ox2), ar2, ai2, sr2, si2);
        end
        if (ov1 === 1'b1) begin
            if (q1.size() == 0) unexpected("d1");
            else cmp("d1", q1.pop_front(), int'(ox1), ar1, ai1, sr1, si1);
        end
        if (ov16 === 1'b1) begin
            if (q16.size() == 0) unexpected("d16");
            else cmp("d16", q16.pop_front(), int'(ox16), ar16, ai16, sr16, si16);
        end
    end

    task automatic drv2(input logic [IV-1:0] r, input logic [IV-1:0] i, input logic se, output int ec);
        @(negedge clk);
        v2 = 1'b1; ir2 = r; iq2 = i; se2 = se; ec = ecount;
    endtask
    task automatic drv1(input logic [IV-1:0] r, input logic [IV-1:0] i, input logic se, output int ec);
        @(negedge clk);
        v1 = 1'b1; ir1 = r; iq1 = i; se1 = se; ec = ecount;
    endtask
    task automatic drv16(input logic [IV-1:0] r, input logic [IV-1:0] i, output int ec);
        @(negedge clk);
        v16 = 1'b1; ir16 = r; iq16 = i; se16 = 1'b0; ec = ecount;
    endtask
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            v2 = 1'b0; v1 = 1'b0; v16 = 1'b0;
        end
    endtask

    initial begin
        int ec;
        int vals[4];
        int cr[L], ci[L], er[L], ei[L], fr[L], fi[L];
        int fr_r[16][L], fr_i[16][L];

        rstn = 1'b0;
        v2 = 0; v1 = 0; v16 = 0; se2 = 0; se1 = 0; se16 = 0;
        ir2 = '0; iq2 = '0; ir1 = '0; iq1 = '0; ir16 = '0; iq16 = '0;
        repeat (3) @(negedge clk);
        rchk("d2", ov2, int'(ox2), ar2, ai2, sr2, si2);
        rchk("d1", ov1, int'(ox1), ar1, ai1, sr1, si1);
        rchk("d16", ov16, int'(ox16), ar16, ai16, sr16, si16);
        rstn = 1'b1;

        // Basic stream, DEPTH=2: real = beat*10 + k, imag 0.
        for (int b = 0; b < 4; b++) begin
            drv2(pk9f(b * 10, 1), pk9f(0, 0), 1'b0, ec);
            if (b >= 2) q2.push_back('{ec + 1, b - 2, pk10f(20 * (b - 1), 2), pk10f(0, 0),
                                       pk10f(-20, 0), pk10f(0, 0)});
        end
        idle(3);

        // Same frame with gaps of 1..4 idle cycles between beats.
        for (int b = 0; b < 4; b++) begin
            drv2(pk9f(b * 10, 1), pk9f(0, 0), 1'b0, ec);
            if (b >= 2) q2.push_back('{ec + 1, b - 2, pk10f(20 * (b - 1), 2), pk10f(0, 0),
                                       pk10f(-20, 0), pk10f(0, 0)});
            idle(b + 1);
        end

        // Scale latched at beat 0 only: frame A se=1,0,0,0 then frame B se=0,1,1,1.
        vals = '{5, -7, 2, -2};
        for (int b = 0; b < 4; b++) begin
            drv2(pk9f(vals[b], 0), pk9f(0, 0), (b == 0), ec);
            if (b == 2) q2.push_back('{ec + 1, 0, pk10f(4, 0), pk10f(0, 0), pk10f(2, 0), pk10f(0, 0)});
            if (b == 3) q2.push_back('{ec + 1, 1, pk10f(-4, 0), pk10f(0, 0), pk10f(-2, 0), pk10f(0, 0)});
        end
        for (int b = 0; b < 4; b++) begin
            drv2(pk9f(vals[b], 0), pk9f(0, 0), (b != 0), ec);
            if (b == 2) q2.push_back('{ec + 1, 0, pk10f(7, 0), pk10f(0, 0), pk10f(3, 0), pk10f(0, 0)});
            if (b == 3) q2.push_back('{ec + 1, 1, pk10f(-9, 0), pk10f(0, 0), pk10f(-5, 0), pk10f(0, 0)});
        end
        idle(2);

        // Reset mid-frame after 3 beats (in PAIR, cnt=1).
        for (int b = 0; b < 3; b++) begin
            drv2(pk9f(b * 10, 1), pk9f(0, 0), 1'b0, ec);
            if (b == 2) q2.push_back('{ec + 1, 0, pk10f(20, 2), pk10f(0, 0), pk10f(-20, 0), pk10f(0, 0)});
        end
        @(negedge clk);
        v2 = 1'b0; rstn = 1'b0;
        @(negedge clk);
        rchk("d2_midrst", ov2, int'(ox2), ar2, ai2, sr2, si2);
        rstn = 1'b1;
        // Fresh frame: real = beat*10 + k, imag = beat*3 - k.
        for (int b = 0; b < 4; b++) begin
            drv2(pk9f(b * 10, 1), pk9f(b * 3, -1), 1'b0, ec);
            if (b == 2) q2.push_back('{ec + 1, 0, pk10f(20, 2), pk10f(6, -2), pk10f(-20, 0), pk10f(-6, 0)});
            if (b == 3) q2.push_back('{ec + 1, 1, pk10f(40, 2), pk10f(12, -2), pk10f(-20, 0), pk10f(-6, 0)});
        end
        idle(2);

        // DEPTH=1 extremes, unscaled.
        drv1(pk9f(255, 0), pk9f(-256, 0), 1'b0, ec);
        drv1(pk9f(255, 0), pk9f(255, 0), 1'b0, ec);
        q1.push_back('{ec + 1, 0, pk10f(510, 0), pk10f(-1, 0), pk10f(0, 0), pk10f(-511, 0)});
        drv1(pk9f(-256, 0), pk9f(255, 0), 1'b0, ec);
        drv1(pk9f(255, 0), pk9f(-256, 0), 1'b0, ec);
        q1.push_back('{ec + 1, 0, pk10f(-1, 0), pk10f(-1, 0), pk10f(-511, 0), pk10f(511, 0)});
        // DEPTH=1 scaled; scale_en on the pair beat is ignored.
        drv1(pk9f(3, 0), pk9f(-3, 0), 1'b1, ec);
        drv1(pk9f(2, 0), pk9f(0, 0), 1'b0, ec);
        q1.push_back('{ec + 1, 0, pk10f(3, 0), pk10f(-1, 0), pk10f(1, 0), pk10f(-1, 0)});
        drv1(pk9f(-256, 0), pk9f(255, 0), 1'b1, ec);
        drv1(pk9f(-256, 0), pk9f(-256, 0), 1'b1, ec);
        q1.push_back('{ec + 1, 0, pk10f(-256, 0), pk10f(0, 0), pk10f(0, 0), pk10f(256, 0)});
        idle(2);

        // DEPTH=16 continuous random stream, 3 frames back to back.
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < 32; b++) begin
                for (int k = 0; k < L; k++) begin
                    cr[k] = int'($urandom_range(0, 511)) - 256;
                    ci[k] = int'($urandom_range(0, 511)) - 256;
                end
                drv16(pk9a(cr), pk9a(ci), ec);
                if (b < 16) begin
                    fr_r[b] = cr;
                    fr_i[b] = ci;
                end else begin
                    for (int k = 0; k < L; k++) begin
                        er[k] = fr_r[b-16][k] + cr[k];
                        ei[k] = fr_i[b-16][k] + ci[k];
                        fr[k] = fr_r[b-16][k] - cr[k];
                        fi[k] = fr_i[b-16][k] - ci[k];
                    end
                    q16.push_back('{ec + 1, b - 16, pk10a(er), pk10a(ei), pk10a(fr), pk10a(fi)});
                end
            end
        end
        idle(6);

        chki("d2.pending", q2.size(), 0);
        chki("d1.pending", q1.size(), 0);
        chki("d16.pending", q16.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
